// File: rtl/audio_pkg.sv
// Shared audio-path definitions for the envelope, mixer and DAC stages.
// Holds the default sample/volume widths, the mixer scan state encoding
// and helpers that derive product/accumulator widths from the voice count.
package audio_pkg;

  localparam int VOICES_DEF = 4;
  localparam int BD_DEF     = 12;
  localparam int VOL_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    MASTER = 2'd2,
    SAT    = 2'd3
  } mix_state_e;

  // Signed sample times zero-extended unsigned volume.
  function automatic int prod_w(input int bd, input int vol_w);
    return bd + vol_w + 1;
  endfunction

  // Sum of all voice products; headroom grows with log2 of the voice count.
  function automatic int acc_w(input int voices, input int bd, input int vol_w);
    return prod_w(bd, vol_w) + $clog2(voices);
  endfunction

  // Accumulator times zero-extended unsigned master volume.
  function automatic int mac_w(input int voices, input int bd, input int vol_w);
    return acc_w(voices, bd, vol_w) + vol_w + 1;
  endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Bus bundle between the voice sources / DAC stage and voice_mixer.
// master: the side that provides samples, volumes and ticks (and reads the mix).
// slave : the mixer itself.
//   sample_tick   one-cycle strobe at the sample rate
//   voice_sample  packed signed samples, voice 0 in the LSBs
//   voice_volume  packed unsigned envelope volumes
//   voice_enable  per-voice mute mask
//   master_volume unsigned master gain
//   clear_flags   pulse clearing clip/overrun
//   mix_out       signed mixed sample, mix_valid pulses when it updates
//   clip/overrun  sticky status flags
interface voice_mixer_if
  import audio_pkg::*;
#(
  parameter int VOICES = VOICES_DEF,
  parameter int BD     = BD_DEF,
  parameter int VOL_W  = VOL_W_DEF
);

  logic                      sample_tick;
  logic [VOICES*BD-1:0]      voice_sample;
  logic [VOICES*VOL_W-1:0]   voice_volume;
  logic [VOICES-1:0]         voice_enable;
  logic [VOL_W-1:0]          master_volume;
  logic                      clear_flags;
  logic [BD-1:0]             mix_out;
  logic                      mix_valid;
  logic                      clip;
  logic                      overrun;

  modport master (
    output sample_tick, voice_sample, voice_volume, voice_enable,
           master_volume, clear_flags,
    input  mix_out, mix_valid, clip, overrun
  );

  modport slave (
    input  sample_tick, voice_sample, voice_volume, voice_enable,
           master_volume, clear_flags,
    output mix_out, mix_valid, clip, overrun
  );

endinterface

// File: rtl/voice_mac.sv
// Shared signed x unsigned multiply-accumulate unit.
//   a      signed operand (A_W bits)
//   b      unsigned operand (B_W bits), zero-extended before multiplying
//   clr    zero the result register (has priority)
//   en     update the result register this cycle
//   accum  1: result += a*b, 0: result = a*b (load)
//   result registered product / running sum (A_W+B_W+1 bits, signed)
module voice_mac
  import audio_pkg::*;
#(
  parameter int A_W = 23,
  parameter int B_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    accum,
  input  logic signed [A_W-1:0]   a,
  input  logic        [B_W-1:0]   b,
  output logic signed [A_W+B_W:0] result
);

  localparam int R_W = A_W + B_W + 1;

  logic signed [R_W-1:0] a_ext;
  logic signed [R_W-1:0] b_ext;
  logic signed [R_W-1:0] prod;
  logic signed [R_W-1:0] result_d;
  logic signed [R_W-1:0] result_q;

  // Operands extended to the full result width so the truncated product is exact.
  always_comb begin
    a_ext = {{(B_W + 1){a[A_W-1]}}, a};
    b_ext = {{(A_W + 1){1'b0}}, b};
    prod  = a_ext * b_ext;
  end

  // Next result: clear, accumulate, load or hold.
  always_comb begin
    result_d = result_q;
    if (clr) begin
      result_d = {R_W{1'b0}};
    end else if (en) begin
      if (accum) begin
        result_d = result_q + prod;
      end else begin
        result_d = prod;
      end
    end else begin
      result_d = result_q;
    end
  end

  // Result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= {R_W{1'b0}};
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/voice_mixer.sv
// Per-sample voice mixer. On sample_tick it snapshots all voice inputs, then
// scans the voices through one shared MAC (one voice per cycle), reuses the
// MAC to apply the master volume, floors by 2^(2*VOL_W), saturates to BD bits
// and registers the result with a one-cycle mix_valid pulse.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         voice_mixer_if slave modport (inputs, mix output, flags)
module voice_mixer
  import audio_pkg::*;
#(
  parameter int VOICES = VOICES_DEF,
  parameter int BD     = BD_DEF,
  parameter int VOL_W  = VOL_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  voice_mixer_if.slave  bus
);

  localparam int ACC_W = acc_w(VOICES, BD, VOL_W);
  localparam int MAC_W = mac_w(VOICES, BD, VOL_W);
  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int SHIFT = 2 * VOL_W;

  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(VOICES - 1);
  localparam logic signed [MAC_W-1:0] SAT_MAX  = {{(MAC_W - BD + 1){1'b0}}, {(BD - 1){1'b1}}};
  localparam logic signed [MAC_W-1:0] SAT_MIN  = {{(MAC_W - BD + 1){1'b1}}, {(BD - 1){1'b0}}};

  mix_state_e                state_d, state_q;
  logic [IDX_W-1:0]          idx_d, idx_q;
  logic [VOICES*BD-1:0]      samp_d, samp_q;
  logic [VOICES*VOL_W-1:0]   vol_d, vol_q;
  logic [VOICES-1:0]         en_d, en_q;
  logic [VOL_W-1:0]          mvol_d, mvol_q;
  logic [BD-1:0]             mix_out_d, mix_out_q;
  logic                      mix_valid_d, mix_valid_q;
  logic                      clip_d, clip_q;
  logic                      overrun_d, overrun_q;

  logic                      mac_clr;
  logic                      mac_en;
  logic                      mac_accum;
  logic signed [ACC_W-1:0]   mac_a;
  logic        [VOL_W-1:0]   mac_b;
  logic signed [MAC_W-1:0]   mac_result;

  logic [BD-1:0]             samp_cur;
  logic [VOL_W-1:0]          vol_cur;
  logic                      en_cur;
  logic signed [MAC_W-1:0]   scaled;
  logic                      sat_hi;
  logic                      sat_lo;
  logic                      clip_set;
  logic                      overrun_set;

  // Snapshot fields of the voice currently being scanned.
  assign samp_cur = samp_q[BD * int'(idx_q) +: BD];
  assign vol_cur  = vol_q[VOL_W * int'(idx_q) +: VOL_W];
  assign en_cur   = en_q[idx_q];

  // MAC operand mux: voice sample x envelope in SCAN, accumulator x master in MASTER.
  always_comb begin
    mac_a = {ACC_W{1'b0}};
    mac_b = {VOL_W{1'b0}};
    case (state_q)
      SCAN: begin
        mac_a = {{(ACC_W - BD){samp_cur[BD-1]}}, samp_cur};
        mac_b = vol_cur;
      end
      MASTER: begin
        // The voice sum always fits ACC_W, so the low bits are the whole value.
        mac_a = mac_result[ACC_W-1:0];
        mac_b = mvol_q;
      end
      default: begin
        mac_a = {ACC_W{1'b0}};
        mac_b = {VOL_W{1'b0}};
      end
    endcase
  end

  voice_mac #(
    .A_W (ACC_W),
    .B_W (VOL_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (mac_clr),
    .en     (mac_en),
    .accum  (mac_accum),
    .a      (mac_a),
    .b      (mac_b),
    .result (mac_result)
  );

  // Both gains are /256, so drop 2*VOL_W bits; arithmetic shift floors toward -inf.
  always_comb begin
    scaled = mac_result >>> SHIFT;
    sat_hi = (scaled > SAT_MAX);
    sat_lo = (scaled < SAT_MIN);
  end

  // Scan FSM next state, MAC control, snapshot capture and output update.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    samp_d      = samp_q;
    vol_d       = vol_q;
    en_d        = en_q;
    mvol_d      = mvol_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    mac_accum   = 1'b0;
    clip_set    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sample_tick) begin
          samp_d  = bus.voice_sample;
          vol_d   = bus.voice_volume;
          en_d    = bus.voice_enable;
          mvol_d  = bus.master_volume;
          mac_clr = 1'b1;
          idx_d   = {IDX_W{1'b0}};
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        // Muted voices simply skip the accumulate.
        mac_en    = en_cur;
        mac_accum = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = MASTER;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = SCAN;
        end
      end
      MASTER: begin
        mac_en    = 1'b1;
        mac_accum = 1'b0;
        state_d   = SAT;
      end
      SAT: begin
        if (sat_hi) begin
          mix_out_d = SAT_MAX[BD-1:0];
          clip_set  = 1'b1;
        end else if (sat_lo) begin
          mix_out_d = SAT_MIN[BD-1:0];
          clip_set  = 1'b1;
        end else begin
          mix_out_d = scaled[BD-1:0];
        end
        mix_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Sticky flags; a set event in the same cycle as clear_flags wins.
  always_comb begin
    overrun_set = bus.sample_tick && (state_q != IDLE);
    if (clip_set) begin
      clip_d = 1'b1;
    end else if (bus.clear_flags) begin
      clip_d = 1'b0;
    end else begin
      clip_d = clip_q;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (bus.clear_flags) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= {IDX_W{1'b0}};
      samp_q      <= {(VOICES * BD){1'b0}};
      vol_q       <= {(VOICES * VOL_W){1'b0}};
      en_q        <= {VOICES{1'b0}};
      mvol_q      <= {VOL_W{1'b0}};
      mix_out_q   <= {BD{1'b0}};
      mix_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      samp_q      <= samp_d;
      vol_q       <= vol_d;
      en_q        <= en_d;
      mvol_q      <= mvol_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      clip_q      <= clip_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.mix_out   = mix_out_q;
  assign bus.mix_valid = mix_valid_q;
  assign bus.clip      = clip_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed testbench for voice_mixer (VOICES=4, BD=12, VOL_W=8).
// Expected values are hand-computed: out = floor(sum(s*v) * m / 65536), clamped.
module tb_voice_mixer;
  import audio_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  voice_mixer_if #(.VOICES(4), .BD(12), .VOL_W(8)) bus ();

  voice_mixer #(.VOICES(4), .BD(12), .VOL_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_voice(input int i, input logic [11:0] s, input logic [7:0] v);
    bus.voice_sample[i*12 +: 12] = s;
    bus.voice_volume[i*8 +: 8]   = v;
  endtask

  task automatic clear_all_voices();
    bus.voice_sample = 48'd0;
    bus.voice_volume = 32'd0;
    bus.voice_enable = 4'b0000;
  endtask

  // Tick is sampled at the posedge between the two negedges; returns half a cycle after.
  task automatic fire_tick();
    @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear_flags = 1'b1;
    @(negedge clk);
    bus.clear_flags = 1'b0;
  endtask

  // Watches 20 cycles; lat = cycle index (tick cycle = 0) of first mix_valid, -1 if none.
  task automatic wait_valid(output int lat, output int pulses);
    lat    = -1;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.mix_valid === 1'b1) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.mix_out !== 12'd0) begin
      $display("FAIL reset_mix_out: got %0d want 0", bus.mix_out); fails++;
    end
    checks++;
    if (bus.mix_valid !== 1'b0) begin
      $display("FAIL reset_mix_valid: got %b want 0", bus.mix_valid); fails++;
    end
    checks++;
    if (bus.clip !== 1'b0) begin
      $display("FAIL reset_clip: got %b want 0", bus.clip); fails++;
    end
    checks++;
    if (bus.overrun !== 1'b0) begin
      $display("FAIL reset_overrun: got %b want 0", bus.overrun); fails++;
    end
  endtask

  task automatic test_single_voice();
    int lat;
    int pulses;
    clear_all_voices();
    set_voice(0, 12'd1000, 8'd128);
    bus.voice_enable  = 4'b0001;
    bus.master_volume = 8'd255;
    fire_tick();
    wait_valid(lat, pulses);
    checks++;
    if (lat !== 7) begin
      $display("FAIL single_latency: got %0d want 7", lat); fails++;
    end
    checks++;
    if (pulses !== 1) begin
      $display("FAIL single_pulses: got %0d want 1", pulses); fails++;
    end
    checks++;
    if (bus.mix_out !== 12'd498) begin
      $display("FAIL single_pos_value: got %0d want 498", $signed(bus.mix_out)); fails++;
    end
    checks++;
    if (bus.clip !== 1'b0) begin
      $display("FAIL single_clip: got %b want 0", bus.clip); fails++;
    end
    set_voice(0, -12'sd1000, 8'd128);
    fire_tick();
    wait_valid(lat, pulses);
    checks++;
    if (bus.mix_out !== -12'sd499) begin
      $display("FAIL single_neg_floor: got %0d want -499", $signed(bus.mix_out)); fails++;
    end
  endtask

  task automatic test_pos_sat();
    int lat;
    int pulses;
    for (int i = 0; i < 4; i++) set_voice(i, 12'd2047, 8'd255);
    bus.voice_enable  = 4'b1111;
    bus.master_volume = 8'd255;
    fire_tick();
    wait_valid(lat, pulses);
    checks++;
    if (bus.mix_out !== 12'h7FF) begin
      $display("FAIL pos_sat_value: got %0d want 2047", $signed(bus.mix_out)); fails++;
    end
    checks++;
    if (bus.clip !== 1'b1) begin
      $display("FAIL pos_sat_clip: got %b want 1", bus.clip); fails++;
    end
    pulse_clear();
    checks++;
    if (bus.clip !== 1'b0) begin
      $display("FAIL pos_sat_clear: got %b want 0", bus.clip); fails++;
    end
  endtask

  task automatic test_reset_midscan();
    int lat;
    int pulses;
    // Leave a saturated result and clip set so the reset has something to clear.
    for (int i = 0; i < 4; i++) set_voice(i, 12'd2047, 8'd255);
    bus.voice_enable  = 4'b1111;
    bus.master_volume = 8'd255;
    fire_tick();
    wait_valid(lat, pulses);
    fire_tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mix_out !== 12'd0) begin
      $display("FAIL midscan_mix_out: got %0d want 0", $signed(bus.mix_out)); fails++;
    end
    checks++;
    if (bus.clip !== 1'b0 || bus.overrun !== 1'b0 || bus.mix_valid !== 1'b0) begin
      $display("FAIL midscan_flags: got clip=%b overrun=%b valid=%b want 0/0/0",
               bus.clip, bus.overrun, bus.mix_valid); fails++;
    end
    checks++;
    if (u_dut.state_q !== IDLE) begin
      $display("FAIL midscan_state: got %0d want IDLE", u_dut.state_q); fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(lat, pulses);
    checks++;
    if (pulses !== 0) begin
      $display("FAIL midscan_no_valid: got %0d pulses want 0", pulses); fails++;
    end
  endtask

  task automatic test_neg_sat();
    int lat;
    int pulses;
    for (int i = 0; i < 4; i++) set_voice(i, 12'h800, 8'd255);
    bus.voice_enable  = 4'b1111;
    bus.master_volume = 8'd255;
    fire_tick();
    wait_valid(lat, pulses);
    checks++;
    if (bus.mix_out !== 12'h800) begin
      $display("FAIL neg_sat_value: got %0d want -2048", $signed(bus.mix_out)); fails++;
    end
    checks++;
    if (bus.clip !== 1'b1) begin
      $display("FAIL neg_sat_clip: got %b want 1", bus.clip); fails++;
    end
    pulse_clear();
  endtask

  task automatic test_mute_snapshot();
    int lat;
    int pulses;
    for (int i = 0; i < 4; i++) set_voice(i, 12'd1500, 8'd200);
    bus.voice_enable  = 4'b0000;
    bus.master_volume = 8'd255;
    fire_tick();
    wait_valid(lat, pulses);
    checks++;
    if (bus.mix_out !== 12'd0 || pulses !== 1) begin
      $display("FAIL mute_value: got %0d (pulses %0d) want 0 (1)", $signed(bus.mix_out), pulses);
      fails++;
    end
    clear_all_voices();
    set_voice(0, 12'd1000, 8'd128);
    bus.voice_enable = 4'b0001;
    fire_tick();
    @(negedge clk);
    set_voice(0, 12'd0, 8'd0);
    bus.voice_enable  = 4'b0000;
    bus.master_volume = 8'd0;
    wait_valid(lat, pulses);
    checks++;
    if (bus.mix_out !== 12'd498) begin
      $display("FAIL snapshot_value: got %0d want 498", $signed(bus.mix_out)); fails++;
    end
  endtask

  task automatic test_overrun();
    int lat;
    int pulses;
    clear_all_voices();
    set_voice(0, 12'd400, 8'd200);
    bus.voice_enable  = 4'b0001;
    bus.master_volume = 8'd128;
    checks++;
    if (bus.overrun !== 1'b0) begin
      $display("FAIL overrun_initial: got %b want 0", bus.overrun); fails++;
    end
    fire_tick();
    @(negedge clk);
    @(negedge clk);
    // Second tick three cycles after the first, with clear_flags in the same cycle.
    set_voice(0, -12'sd2000, 8'd200);
    bus.sample_tick = 1'b1;
    bus.clear_flags = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    bus.clear_flags = 1'b0;
    wait_valid(lat, pulses);
    checks++;
    if (pulses !== 1) begin
      $display("FAIL overrun_pulses: got %0d want 1", pulses); fails++;
    end
    checks++;
    if (lat !== 4) begin
      $display("FAIL overrun_first_latency: got %0d want 4", lat); fails++;
    end
    checks++;
    if (bus.mix_out !== 12'd156) begin
      $display("FAIL overrun_first_value: got %0d want 156", $signed(bus.mix_out)); fails++;
    end
    checks++;
    if (bus.overrun !== 1'b1) begin
      $display("FAIL overrun_flag: got %b want 1", bus.overrun); fails++;
    end
    repeat (200) @(negedge clk);
    pulse_clear();
    checks++;
    if (bus.overrun !== 1'b0) begin
      $display("FAIL overrun_clear: got %b want 0", bus.overrun); fails++;
    end
    fire_tick();
    wait_valid(lat, pulses);
    checks++;
    if (lat !== 7 || bus.mix_out !== -12'sd782) begin
      $display("FAIL overrun_next_sample: got %0d (lat %0d) want -782 (lat 7)",
               $signed(bus.mix_out), lat); fails++;
    end
    checks++;
    if (bus.overrun !== 1'b0) begin
      $display("FAIL overrun_stays_clear: got %b want 0", bus.overrun); fails++;
    end
  endtask

  initial begin
    checks            = 0;
    fails             = 0;
    rst_n             = 1'b0;
    bus.sample_tick   = 1'b0;
    bus.clear_flags   = 1'b0;
    bus.master_volume = 8'd0;
    clear_all_voices();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single_voice();
    test_pos_sat();
    test_reset_midscan();
    test_neg_sat();
    test_mute_snapshot();
    test_overrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
